// File: rtl/load_store_unit.sv
// Load/store unit: bridges core load/store requests onto a word-wide request/ack memory bus.
// Define MISALIGN_CHECK_EN to reject misaligned halfword/word accesses instead of masking them.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        bus_we_q, bus_we_d;
  size_e       size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  offset_q, offset_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;

  logic        req_valid;
  size_e       req_size;
  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        misalign_stop;
  logic [31:0] lane_shifted;
  logic [31:0] load_fmt;

  // Request decode; invalid func3 codes fall through to a word access.
  always_comb begin
    req_valid = mem_read | mem_write;
    case (func3)
      3'b000, 3'b100: req_size = SzByte;
      3'b001, 3'b101: req_size = SzHalf;
      default:        req_size = SzWord;
    endcase

    req_off   = address[1:0];
    req_be    = 4'b1111;
    req_wdata = write_data;
    case (req_size)
      SzByte: begin
        req_be    = 4'b0001 << address[1:0];
        req_wdata = {4{write_data[7:0]}};
      end
      SzHalf: begin
        req_off   = {address[1], 1'b0};
        req_be    = 4'b0011 << {address[1], 1'b0};
        req_wdata = {2{write_data[15:0]}};
      end
      default: begin
        req_off = 2'b00;
      end
    endcase
    // Loads always fetch the whole word and pick the lane on return.
    if (!mem_write) begin
      req_be = 4'b1111;
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign misalign_stop = ((req_size == SzHalf) && address[0]) ||
                         ((req_size == SzWord) && (address[1:0] != 2'b00));
`else
  assign misalign_stop = 1'b0;
`endif

  // Returned-data lane select and extension.
  always_comb begin
    lane_shifted = bus_rdata >> {offset_q, 3'b000};
    case (size_q)
      SzByte: begin
        load_fmt = unsigned_q ? {24'b0, lane_shifted[7:0]}
                              : {{24{lane_shifted[7]}}, lane_shifted[7:0]};
      end
      SzHalf: begin
        load_fmt = unsigned_q ? {16'b0, lane_shifted[15:0]}
                              : {{16{lane_shifted[15]}}, lane_shifted[15:0]};
      end
      default: begin
        load_fmt = bus_rdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    bus_we_d    = bus_we_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    offset_d    = offset_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    stall       = 1'b0;

    case (state_q)
      StIdle: begin
        // Gated by reset so a held request cannot stall the core during reset.
        if (req_valid && reset) begin
          stall       = 1'b1;
          bus_addr_d  = {address[31:2], 2'b00};
          bus_wdata_d = req_wdata;
          bus_be_d    = req_be;
          bus_we_d    = mem_write;
          size_d      = req_size;
          unsigned_d  = func3[2];
          offset_d    = req_off;
          cnt_d       = 16'd0;
          if (misalign_stop) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_d = StDone;
          if (!bus_we_q) begin
            load_data_d = load_fmt;
          end
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      bus_we_q    <= 1'b0;
      size_q      <= SzWord;
      unsigned_q  <= 1'b0;
      offset_q    <= 2'b00;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      bus_we_q    <= bus_we_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      offset_q    <= offset_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end

  assign bus_req    = (state_q == StReq);
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;
  assign load_data  = load_data_q;
  assign load_valid = (state_q == StDone) && !bus_we_q && !err_q;
  assign bus_err    = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (instantiated with TIMEOUT_CYC=4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  load_store_unit #(
    .TIMEOUT_CYC(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .func3     (func3),
    .address   (address),
    .write_data(write_data),
    .stall     (stall),
    .load_data (load_data),
    .load_valid(load_valid),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Observations of one transaction, filled in by access().
  int          obs_done;
  int          obs_req_cycles;
  int          obs_stall_cycles;
  int          obs_lv_count;
  int          obs_err_count;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [31:0] obs_ld;
  logic        obs_lv_after;
  logic        obs_err_after;

  // Drives one request and acks on the ack_at-th bus_req cycle (never if ack_at < 1).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rdata);
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    func3      = f3;
    address    = addr;
    write_data = wd;
    bus_rdata  = rdata;
    bus_ack    = 1'b0;
    obs_done = -1; obs_req_cycles = 0; obs_stall_cycles = 0; obs_lv_count = 0;
    obs_err_count = 0; obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0; obs_ld = '0;
    #1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (stall) obs_stall_cycles++;
      if (load_valid) obs_lv_count++;
      if (bus_err) obs_err_count++;
      if (bus_req) begin
        obs_req_cycles++;
        if (obs_req_cycles == 1) begin
          obs_addr = bus_addr; obs_wdata = bus_wdata; obs_be = bus_be; obs_we = bus_we;
        end
        bus_ack = (obs_req_cycles == ack_at);
      end else begin
        bus_ack = 1'b0;
      end
      if (cyc > 0 && !stall) begin
        obs_done = cyc;
        obs_ld   = load_data;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    bus_ack   = 1'b0;
    #1;
    obs_lv_after  = load_valid;
    obs_err_after = bus_err;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    mem_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else pass_cnt++;
    chk_cnt++; if (bus_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus_req); else pass_cnt++;
    chk_cnt++; if (load_valid !== 1'b0) $display("FAIL rst_lv: got %b want 0", load_valid); else pass_cnt++;
    chk_cnt++; if (bus_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus_err); else pass_cnt++;
    chk_cnt++; if (bus_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus_we); else pass_cnt++;
    chk_cnt++; if (load_data !== 32'h0) $display("FAIL rst_ld: got %h want 0", load_data); else pass_cnt++;
    chk_cnt++; if (bus_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus_addr); else pass_cnt++;
    chk_cnt++; if (bus_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", bus_wdata); else pass_cnt++;
    chk_cnt++; if (bus_be !== 4'h0) $display("FAIL rst_be: got %h want 0", bus_be); else pass_cnt++;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lw;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
    chk_cnt++; if (obs_addr !== 32'h100) $display("FAIL lw_addr: got %h want 00000100", obs_addr); else pass_cnt++;
    chk_cnt++; if (obs_be !== 4'hF) $display("FAIL lw_be: got %h want f", obs_be); else pass_cnt++;
    chk_cnt++; if (obs_we !== 1'b0) $display("FAIL lw_we: got %b want 0", obs_we); else pass_cnt++;
    chk_cnt++; if (obs_ld !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h want deadbeef", obs_ld); else pass_cnt++;
    chk_cnt++; if (obs_done !== 3) $display("FAIL lw_valid_cycle: got %0d want 3", obs_done); else pass_cnt++;
    chk_cnt++; if (obs_stall_cycles !== 3) $display("FAIL lw_stall_cycles: got %0d want 3", obs_stall_cycles); else pass_cnt++;
    chk_cnt++; if (obs_req_cycles !== 2) $display("FAIL lw_req_cycles: got %0d want 2", obs_req_cycles); else pass_cnt++;
    chk_cnt++; if (obs_lv_count !== 1) $display("FAIL lw_lv_count: got %0d want 1", obs_lv_count); else pass_cnt++;
    chk_cnt++; if (obs_lv_after !== 1'b0) $display("FAIL lw_lv_pulse: got %b want 0", obs_lv_after); else pass_cnt++;
    // Zero-wait ack gives the two-cycle minimum latency.
    access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 1, 32'h0BAD_F00D);
    chk_cnt++; if (obs_done !== 2) $display("FAIL lw0_valid_cycle: got %0d want 2", obs_done); else pass_cnt++;
    chk_cnt++; if (obs_ld !== 32'h0BAD_F00D) $display("FAIL lw0_data: got %h want 0badf00d", obs_ld); else pass_cnt++;
  endtask

  task automatic test_sign_ext;
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
    chk_cnt++; if (obs_ld !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", obs_ld); else pass_cnt++;
    access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
    chk_cnt++; if (obs_ld !== 32'h0000_0080) $display("FAIL lbu_data: got %h want 00000080", obs_ld); else pass_cnt++;
    access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h80FF_1234);
    chk_cnt++; if (obs_ld !== 32'hFFFF_80FF) $display("FAIL lh_data: got %h want ffff80ff", obs_ld); else pass_cnt++;
    chk_cnt++; if (obs_be !== 4'hF) $display("FAIL lh_be: got %h want f", obs_be); else pass_cnt++;
    access(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 1, 32'h80FF_1234);
    chk_cnt++; if (obs_ld !== 32'h0000_1234) $display("FAIL lhu_data: got %h want 00001234", obs_ld); else pass_cnt++;
  endtask

  task automatic test_store;
    access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 1, 32'hFFFF_FFFF);
    chk_cnt++; if (obs_we !== 1'b1) $display("FAIL sh_we: got %b want 1", obs_we); else pass_cnt++;
    chk_cnt++; if (obs_be !== 4'hC) $display("FAIL sh_be: got %h want c", obs_be); else pass_cnt++;
    chk_cnt++; if (obs_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); else pass_cnt++;
    chk_cnt++; if (obs_addr !== 32'h200) $display("FAIL sh_addr: got %h want 00000200", obs_addr); else pass_cnt++;
    chk_cnt++; if (obs_lv_count !== 0) $display("FAIL sh_lv: got %0d want 0", obs_lv_count); else pass_cnt++;
    chk_cnt++; if (obs_ld !== 32'h0000_1234) $display("FAIL sh_ld_kept: got %h want 00001234", obs_ld); else pass_cnt++;
    access(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56EF, 1, 32'h0);
    chk_cnt++; if (obs_be !== 4'h2) $display("FAIL sb_be: got %h want 2", obs_be); else pass_cnt++;
    chk_cnt++; if (obs_wdata !== 32'hEFEF_EFEF) $display("FAIL sb_wdata: got %h want efefefef", obs_wdata); else pass_cnt++;
    // Read and write together is a store.
    access(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h1111_1111);
    chk_cnt++; if (obs_we !== 1'b1) $display("FAIL rw_we: got %b want 1", obs_we); else pass_cnt++;
    chk_cnt++; if (obs_wdata !== 32'hCAFE_F00D) $display("FAIL rw_wdata: got %h want cafef00d", obs_wdata); else pass_cnt++;
    chk_cnt++; if (obs_lv_count !== 0) $display("FAIL rw_lv: got %0d want 0", obs_lv_count); else pass_cnt++;
  endtask

  task automatic test_invalid_func3;
    access(1'b1, 1'b0, 3'b011, 32'h0000_0108, 32'h0, 1, 32'h8765_4321);
    chk_cnt++; if (obs_ld !== 32'h8765_4321) $display("FAIL f3_011_data: got %h want 87654321", obs_ld); else pass_cnt++;
    access(1'b1, 1'b0, 3'b110, 32'h0000_010C, 32'h0, 1, 32'hFFFF_8001);
    chk_cnt++; if (obs_ld !== 32'hFFFF_8001) $display("FAIL f3_110_data: got %h want ffff8001", obs_ld); else pass_cnt++;
  endtask

  task automatic test_timeout;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0110, 32'h0, 0, 32'h5555_5555);
    chk_cnt++; if (obs_req_cycles !== 4) $display("FAIL to_req_cycles: got %0d want 4", obs_req_cycles); else pass_cnt++;
    chk_cnt++; if (obs_err_count !== 1) $display("FAIL to_err: got %0d want 1", obs_err_count); else pass_cnt++;
    chk_cnt++; if (obs_done !== 5) $display("FAIL to_release_cycle: got %0d want 5", obs_done); else pass_cnt++;
    chk_cnt++; if (obs_lv_count !== 0) $display("FAIL to_lv: got %0d want 0", obs_lv_count); else pass_cnt++;
    chk_cnt++; if (obs_ld !== 32'hFFFF_8001) $display("FAIL to_ld_kept: got %h want ffff8001", obs_ld); else pass_cnt++;
    chk_cnt++; if (obs_err_after !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", obs_err_after); else pass_cnt++;
  endtask

  task automatic test_misalign;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 32'h1122_3344);
`ifdef MISALIGN_CHECK_EN
    chk_cnt++; if (obs_err_count !== 1) $display("FAIL mis_err: got %0d want 1", obs_err_count); else pass_cnt++;
    chk_cnt++; if (obs_req_cycles !== 0) $display("FAIL mis_req: got %0d want 0", obs_req_cycles); else pass_cnt++;
    chk_cnt++; if (obs_done !== 1) $display("FAIL mis_done_cycle: got %0d want 1", obs_done); else pass_cnt++;
    chk_cnt++; if (obs_lv_count !== 0) $display("FAIL mis_lv: got %0d want 0", obs_lv_count); else pass_cnt++;
    access(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0, 1, 32'h1122_3344);
    chk_cnt++; if (obs_err_count !== 1) $display("FAIL mis_h_err: got %0d want 1", obs_err_count); else pass_cnt++;
    chk_cnt++; if (obs_req_cycles !== 0) $display("FAIL mis_h_req: got %0d want 0", obs_req_cycles); else pass_cnt++;
`else
    chk_cnt++; if (obs_addr !== 32'h100) $display("FAIL mask_addr: got %h want 00000100", obs_addr); else pass_cnt++;
    chk_cnt++; if (obs_ld !== 32'h1122_3344) $display("FAIL mask_w_data: got %h want 11223344", obs_ld); else pass_cnt++;
    chk_cnt++; if (obs_err_count !== 0) $display("FAIL mask_err: got %0d want 0", obs_err_count); else pass_cnt++;
    access(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0, 1, 32'h1122_3344);
    chk_cnt++; if (obs_ld !== 32'h0000_1122) $display("FAIL mask_h_data: got %h want 00001122", obs_ld); else pass_cnt++;
    chk_cnt++; if (obs_lv_count !== 1) $display("FAIL mask_h_lv: got %0d want 1", obs_lv_count); else pass_cnt++;
`endif
  endtask

  task automatic test_ack_outside;
    @(negedge clk);
    bus_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_cnt++; if (load_valid !== 1'b0) $display("FAIL idle_ack_lv: got %b want 0", load_valid); else pass_cnt++;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL idle_ack_stall: got %b want 0", stall); else pass_cnt++;
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; address = 32'h180; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++; if (bus_req !== 1'b1) $display("FAIL mid_req_before: got %b want 1", bus_req); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    chk_cnt++; if (bus_req !== 1'b0) $display("FAIL mid_req_async: got %b want 0", bus_req); else pass_cnt++;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL mid_stall_async: got %b want 0", stall); else pass_cnt++;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++; if (load_valid !== 1'b0) $display("FAIL mid_no_lv: got %b want 0", load_valid); else pass_cnt++;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0184, 32'h0, 1, 32'h5A5A_A5A5);
    chk_cnt++; if (obs_ld !== 32'h5A5A_A5A5) $display("FAIL mid_next_data: got %h want 5a5aa5a5", obs_ld); else pass_cnt++;
    chk_cnt++; if (obs_done !== 2) $display("FAIL mid_next_cycle: got %0d want 2", obs_done); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1, 32'h0102_0304);
    chk_cnt++; if (obs_ld !== 32'h0102_0304) $display("FAIL b2b_first: got %h want 01020304", obs_ld); else pass_cnt++;
    access(1'b1, 1'b0, 3'b100, 32'h0000_0201, 32'h0, 3, 32'h0000_AB00);
    chk_cnt++; if (obs_ld !== 32'h0000_00AB) $display("FAIL b2b_second: got %h want 000000ab", obs_ld); else pass_cnt++;
    chk_cnt++; if (obs_done !== 4) $display("FAIL b2b_second_cycle: got %0d want 4", obs_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sign_ext();
    test_store();
    test_invalid_func3();
    test_timeout();
    test_misalign();
    test_ack_outside();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
